// File: rtl/uart_bus_bridge.sv
// Serial-command bus initiator: 'W'/'R' byte frames become 16-bit bus writes/reads, results are returned as bytes.
// Latency: bus cycle starts one edge after the last frame byte, lasts WAIT_CYCLES, reply follows immediately.
// Backpressure: reply bytes are held until i_tx_ready; bytes arriving during BUS/TX are dropped.
module uart_bus_bridge #(
    parameter int WAIT_CYCLES = 1,
    parameter int TIMEOUT     = 20000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_dat,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_dat,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busreq,
    output logic [15:0] o_wb_addr,
    output logic        o_wb_cyc,
    output logic        o_wb_we,
    output logic [15:0] o_wb_dat,
    input  logic [15:0] i_wb_dat
);
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] RPL_K = 8'h4B;
    localparam logic [7:0] RPL_Q = 8'h3F;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [3:0]    WAIT_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L, BUS, TX_H, TX_L} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    wait_cnt;
    logic          we_q, two_q;
    logic [7:0]    tx_hi, tx_lo;
    logic [15:0]   addr_q, dat_q;
    logic          in_frame, tmo_hit, bus_last, is_cmd;

    assign in_frame = (state == ADDR_H) || (state == ADDR_L) || (state == DATA_H) || (state == DATA_L);
    assign tmo_hit  = (TIMEOUT != 0) && in_frame && !i_rx_valid && (tmo_cnt == TMO_LAST);
    assign bus_last = (state == BUS) && (wait_cnt == WAIT_LAST);
    assign is_cmd   = (i_rx_dat == CMD_W) || (i_rx_dat == CMD_R);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (i_rx_valid) state_nxt = is_cmd ? ADDR_H : TX_H;
            ADDR_H: if (i_rx_valid) state_nxt = ADDR_L;
                    else if (tmo_hit) state_nxt = IDLE;
            ADDR_L: if (i_rx_valid) state_nxt = we_q ? DATA_H : BUS;
                    else if (tmo_hit) state_nxt = IDLE;
            DATA_H: if (i_rx_valid) state_nxt = DATA_L;
                    else if (tmo_hit) state_nxt = IDLE;
            DATA_L: if (i_rx_valid) state_nxt = BUS;
                    else if (tmo_hit) state_nxt = IDLE;
            BUS:    if (bus_last) state_nxt = TX_H;
            TX_H:   if (i_tx_ready) state_nxt = two_q ? TX_L : IDLE;
            TX_L:   if (i_tx_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busreq   = 1'b0;
        o_wb_cyc   = 1'b0;
        o_wb_we    = 1'b0;
        o_tx_valid = 1'b0;
        o_tx_dat   = 8'h00;
        case (state)
            BUS: begin
                o_busreq = 1'b1;
                o_wb_cyc = 1'b1;
                o_wb_we  = we_q;
            end
            TX_H: begin
                o_tx_valid = 1'b1;
                o_tx_dat   = tx_hi;
            end
            TX_L: begin
                o_tx_valid = 1'b1;
                o_tx_dat   = tx_lo;
            end
            default: ;
        endcase
    end

    assign o_wb_addr = addr_q;
    assign o_wb_dat  = dat_q;

    // Datapath: frame capture, idle-gap timer, bus window length and reply bytes.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tmo_cnt  <= '0;
            wait_cnt <= 4'd0;
            we_q     <= 1'b0;
            two_q    <= 1'b0;
            tx_hi    <= 8'h00;
            tx_lo    <= 8'h00;
            addr_q   <= 16'h0000;
            dat_q    <= 16'h0000;
        end else begin
            tmo_cnt  <= (in_frame && !i_rx_valid) ? tmo_cnt + TW'(1) : '0;
            wait_cnt <= (state == BUS && !bus_last) ? wait_cnt + 4'd1 : 4'd0;
            if (i_rx_valid) begin
                case (state)
                    IDLE: begin
                        if (is_cmd) begin
                            we_q  <= (i_rx_dat == CMD_W);
                            two_q <= (i_rx_dat == CMD_R);
                        end else begin
                            two_q <= 1'b0;
                            tx_hi <= RPL_Q;
                        end
                    end
                    ADDR_H: addr_q[15:8] <= i_rx_dat;
                    ADDR_L: addr_q[7:0]  <= i_rx_dat;
                    DATA_H: dat_q[15:8]  <= i_rx_dat;
                    DATA_L: dat_q[7:0]   <= i_rx_dat;
                    default: ;
                endcase
            end
            if (bus_last) begin
                tx_hi <= we_q ? RPL_K : i_wb_dat[15:8];
                tx_lo <= i_wb_dat[7:0];
            end
        end
    end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: directed frames plus a randomized frame mix checked against a memory-level model.
module tb_uart_bus_bridge;
    localparam int WAITC = 3;
    localparam int TMO   = 100;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [7:0]  i_rx_dat = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  o_tx_dat;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic        o_busreq;
    logic [15:0] o_wb_addr;
    logic        o_wb_cyc;
    logic        o_wb_we;
    logic [15:0] o_wb_dat;
    logic [15:0] i_wb_dat;

    int checks = 0;
    int failures = 0;

    uart_bus_bridge #(.WAIT_CYCLES(WAITC), .TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_rx_dat(i_rx_dat), .i_rx_valid(i_rx_valid),
        .o_tx_dat(o_tx_dat), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_busreq(o_busreq), .o_wb_addr(o_wb_addr), .o_wb_cyc(o_wb_cyc), .o_wb_we(o_wb_we),
        .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat)
    );

    always #5 i_clk = ~i_clk;

    // Bus slave: preloaded memory, or a value that changes every cycle of the window.
    logic [15:0] slave_mem [0:65535];
    int cyc_idx = 0;
    bit vary_mode = 1'b0;
    always @(posedge i_clk) cyc_idx <= o_wb_cyc ? cyc_idx + 1 : 0;
    always @(posedge i_clk) if (o_wb_cyc === 1'b1 && o_wb_we === 1'b1) slave_mem[o_wb_addr] = o_wb_dat;
    assign i_wb_dat = vary_mode ? (16'h1000 + 16'(cyc_idx) * 16'h0111) : slave_mem[o_wb_addr];

    // Reference: memory contents as seen by a master issuing the frames.
    logic [15:0] ref_mem [int];
    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return a ^ 16'h5A5A;
    endfunction

    logic [15:0] q_addr[$], q_dat[$];
    bit          q_we[$], q_ok[$], q_txv[$];
    int          q_len[$];
    logic [7:0]  tx_q[$];
    int          win_len = 0;
    logic [15:0] w_addr, w_dat;
    bit          w_we, w_ok;
    int          busreq_bad = 0;

    always @(negedge i_clk) begin
        if (o_tx_valid === 1'b1 && i_tx_ready === 1'b1) tx_q.push_back(o_tx_dat);
        if (o_busreq !== o_wb_cyc) busreq_bad++;
        if (o_wb_cyc === 1'b1) begin
            if (win_len == 0) begin
                w_addr = o_wb_addr; w_dat = o_wb_dat; w_we = o_wb_we; w_ok = 1'b1;
            end else if (o_wb_addr !== w_addr || o_wb_dat !== w_dat || o_wb_we !== w_we) w_ok = 1'b0;
            if (o_busreq !== 1'b1) w_ok = 1'b0;
            win_len++;
        end else if (win_len != 0) begin
            q_addr.push_back(w_addr); q_dat.push_back(w_dat); q_we.push_back(w_we);
            q_ok.push_back(w_ok); q_len.push_back(win_len); q_txv.push_back(o_tx_valid === 1'b1);
            win_len = 0;
        end
    end

    task automatic clear_mon();
        q_addr.delete(); q_dat.delete(); q_we.delete(); q_ok.delete(); q_len.delete(); q_txv.delete();
        tx_q.delete();
    endtask

    function automatic logic [7:0] tx_at(input int i);
        if (i < tx_q.size()) return tx_q[i];
        return 8'hxx;
    endfunction

    task automatic get_win(input int i, output logic [15:0] a, output logic [15:0] d, output logic we,
                           output int len, output logic ok, output logic txv);
        if (i < q_len.size()) begin
            a = q_addr[i]; d = q_dat[i]; we = q_we[i]; len = q_len[i]; ok = q_ok[i]; txv = q_txv[i];
        end else begin
            a = 'x; d = 'x; we = 1'bx; len = -1; ok = 1'b0; txv = 1'b0;
        end
    endtask

    task automatic cycles(input int n);
        for (int g = 0; g < n; g++) begin @(posedge i_clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_dat = b; i_rx_valid = 1'b1;
        @(posedge i_clk); #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic send_write(input logic [15:0] a, input logic [15:0] d, input int mg);
        send_byte(8'h57); cycles($urandom_range(0, mg));
        send_byte(a[15:8]); cycles($urandom_range(0, mg));
        send_byte(a[7:0]); cycles($urandom_range(0, mg));
        send_byte(d[15:8]); cycles($urandom_range(0, mg));
        send_byte(d[7:0]);
    endtask

    task automatic send_read(input logic [15:0] a, input int mg);
        send_byte(8'h52); cycles($urandom_range(0, mg));
        send_byte(a[15:8]); cycles($urandom_range(0, mg));
        send_byte(a[7:0]);
    endtask

    task automatic wait_tx(input int n, input bit rand_rdy, output int got);
        int k = 0;
        while (tx_q.size() < n && k < 400) begin
            if (rand_rdy) i_tx_ready = 1'($urandom_range(0, 1));
            @(posedge i_clk); #1; k++;
        end
        i_tx_ready = 1'b1;
        got = tx_q.size();
    endtask

    task automatic test_reset();
        i_reset = 1'b0; #3;
        checks++; if (o_wb_cyc !== 1'b0 || o_busreq !== 1'b0 || o_wb_we !== 1'b0) begin failures++;
            $display("FAIL reset_bus: cyc=%b busreq=%b we=%b want 000", o_wb_cyc, o_busreq, o_wb_we); end
        checks++; if (o_tx_valid !== 1'b0 || o_tx_dat !== 8'h00) begin failures++;
            $display("FAIL reset_tx: valid=%b dat=%h want 0 00", o_tx_valid, o_tx_dat); end
        checks++; if (o_wb_addr !== 16'h0000 || o_wb_dat !== 16'h0000) begin failures++;
            $display("FAIL reset_addr_dat: addr=%h dat=%h want 0000 0000", o_wb_addr, o_wb_dat); end
        cycles(3);
        i_reset = 1'b1;
        cycles(3);
        checks++; if (o_wb_cyc !== 1'b0 || o_tx_valid !== 1'b0) begin failures++;
            $display("FAIL reset_idle: cyc=%b tx_valid=%b want 0 0", o_wb_cyc, o_tx_valid); end
    endtask

    task automatic test_write();
        int got; logic [15:0] a, d; logic we, ok, txv; int len;
        clear_mon();
        send_write(16'h1234, 16'hABCD, 0);
        checks++; if (o_wb_cyc !== 1'b1) begin failures++;
            $display("FAIL write_cyc_latency: cyc=%b want 1 one edge after last byte", o_wb_cyc); end
        ref_mem[16'h1234] = 16'hABCD;
        wait_tx(1, 1'b0, got);
        cycles(2);
        checks++; if (tx_q.size() !== 1 || tx_at(0) !== 8'h4B) begin failures++;
            $display("FAIL write_reply: n=%0d byte=%h want 1 4b", tx_q.size(), tx_at(0)); end
        get_win(0, a, d, we, len, ok, txv);
        checks++; if (q_len.size() !== 1 || a !== 16'h1234 || d !== 16'hABCD || we !== 1'b1) begin failures++;
            $display("FAIL write_window: n=%0d addr=%h dat=%h we=%b want 1 1234 abcd 1", q_len.size(), a, d, we); end
        checks++; if (len !== WAITC || ok !== 1'b1) begin failures++;
            $display("FAIL write_window_len: len=%0d stable=%b want %0d 1", len, ok, WAITC); end
        checks++; if (txv !== 1'b1) begin failures++;
            $display("FAIL write_reply_latency: tx_valid=%b in cycle after window want 1", txv); end
    endtask

    task automatic test_read_stall();
        int got, k; bit stable; logic [15:0] exp, a, d; logic we, ok, txv; int len;
        logic [7:0] extra [3];
        extra[0] = 8'h57; extra[1] = 8'h52; extra[2] = 8'h41;
        exp = ref_rd(16'h1234);
        clear_mon();
        i_tx_ready = 1'b0;
        send_read(16'h1234, 0);
        k = 0;
        while (o_tx_valid !== 1'b1 && k < 50) begin @(posedge i_clk); #1; k++; end
        checks++; if (o_tx_valid !== 1'b1) begin failures++;
            $display("FAIL read_reply_timeout: tx_valid=%b want 1 within 50 cycles", o_tx_valid); end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (o_tx_valid !== 1'b1 || o_tx_dat !== exp[15:8]) stable = 1'b0;
            if (i < 3) send_byte(extra[i]); else cycles(1);
        end
        checks++; if (!stable || o_tx_dat !== exp[15:8]) begin failures++;
            $display("FAIL read_stall_hi: dat=%h stable=%b want %h 1", o_tx_dat, stable, exp[15:8]); end
        i_tx_ready = 1'b1; cycles(1); i_tx_ready = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (o_tx_valid !== 1'b1 || o_tx_dat !== exp[7:0]) stable = 1'b0;
            cycles(1);
        end
        checks++; if (!stable || o_tx_dat !== exp[7:0]) begin failures++;
            $display("FAIL read_stall_lo: dat=%h stable=%b want %h 1", o_tx_dat, stable, exp[7:0]); end
        i_tx_ready = 1'b1;
        cycles(3);
        checks++; if (tx_q.size() !== 2 || tx_at(0) !== exp[15:8] || tx_at(1) !== exp[7:0]) begin failures++;
            $display("FAIL read_bytes: n=%0d %h %h want 2 %h %h", tx_q.size(), tx_at(0), tx_at(1), exp[15:8], exp[7:0]); end
        get_win(0, a, d, we, len, ok, txv);
        checks++; if (q_len.size() !== 1 || a !== 16'h1234 || we !== 1'b0 || len !== WAITC) begin failures++;
            $display("FAIL read_window: n=%0d addr=%h we=%b len=%0d want 1 1234 0 %0d", q_len.size(), a, we, len, WAITC); end
        clear_mon();
        send_read(16'h1234, 1);
        wait_tx(2, 1'b0, got);
        cycles(2);
        checks++; if (tx_q.size() !== 2 || tx_at(0) !== exp[15:8] || tx_at(1) !== exp[7:0]) begin failures++;
            $display("FAIL read_after_flood: n=%0d %h %h want 2 %h %h", tx_q.size(), tx_at(0), tx_at(1), exp[15:8], exp[7:0]); end
    endtask

    task automatic test_unknown();
        int got;
        clear_mon();
        send_byte(8'h41);
        wait_tx(1, 1'b0, got);
        cycles(3);
        checks++; if (tx_q.size() !== 1 || tx_at(0) !== 8'h3F || q_len.size() !== 0) begin failures++;
            $display("FAIL unknown_cmd: n=%0d byte=%h windows=%0d want 1 3f 0", tx_q.size(), tx_at(0), q_len.size()); end
    endtask

    task automatic test_timeout();
        int got; logic [15:0] exp, a, d; logic we, ok, txv; int len;
        clear_mon();
        send_byte(8'h57); send_byte(8'h12);
        cycles(TMO - 5);
        send_byte(8'h40); send_byte(8'h56); send_byte(8'h78);
        ref_mem[16'h1240] = 16'h5678;
        wait_tx(1, 1'b0, got);
        cycles(2);
        get_win(0, a, d, we, len, ok, txv);
        checks++; if (tx_at(0) !== 8'h4B || a !== 16'h1240 || d !== 16'h5678 || we !== 1'b1) begin failures++;
            $display("FAIL gap_below_timeout: reply=%h addr=%h dat=%h we=%b want 4b 1240 5678 1", tx_at(0), a, d, we); end
        clear_mon();
        send_byte(8'h57); send_byte(8'h12);
        cycles(TMO + 10);
        checks++; if (q_len.size() !== 0 || tx_q.size() !== 0) begin failures++;
            $display("FAIL timeout_silent: windows=%0d replies=%0d want 0 0", q_len.size(), tx_q.size()); end
        exp = ref_rd(16'h0010);
        send_read(16'h0010, 0);
        wait_tx(2, 1'b0, got);
        cycles(2);
        get_win(0, a, d, we, len, ok, txv);
        checks++; if (tx_at(0) !== exp[15:8] || tx_at(1) !== exp[7:0] || a !== 16'h0010 || we !== 1'b0) begin failures++;
            $display("FAIL read_after_timeout: bytes=%h %h addr=%h we=%b want %h %h 0010 0", tx_at(0), tx_at(1), a, we, exp[15:8], exp[7:0]); end
    endtask

    task automatic test_wait_cycles();
        int got; logic [15:0] exp;
        exp = 16'h1000 + 16'(WAITC - 1) * 16'h0111;
        vary_mode = 1'b1;
        clear_mon();
        send_read(16'h0001, 0);
        wait_tx(2, 1'b0, got);
        cycles(2);
        vary_mode = 1'b0;
        checks++; if (tx_q.size() !== 2 || tx_at(0) !== exp[15:8] || tx_at(1) !== exp[7:0]) begin failures++;
            $display("FAIL wait_sample_point: n=%0d %h %h want 2 %h %h", tx_q.size(), tx_at(0), tx_at(1), exp[15:8], exp[7:0]); end
    endtask

    task automatic test_random();
        int got, kind, en, len; bit ewin, ewe;
        logic [15:0] ra, rd, a, d, exp; logic [7:0] e0, e1, b; logic we, ok, txv;
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 4);
            ra = {8'h03, 4'h0, 4'($urandom_range(0, 15))};
            rd = 16'($urandom);
            e1 = 8'hxx;
            clear_mon();
            if (kind <= 1) begin
                send_write(ra, rd, 3);
                ref_mem[int'(ra)] = rd;
                e0 = 8'h4B; en = 1; ewin = 1'b1; ewe = 1'b1;
            end else if (kind <= 3) begin
                exp = ref_rd(ra);
                send_read(ra, 3);
                e0 = exp[15:8]; e1 = exp[7:0]; en = 2; ewin = 1'b1; ewe = 1'b0;
            end else begin
                b = 8'($urandom);
                if (b == 8'h57 || b == 8'h52) b = 8'h00;
                send_byte(b);
                e0 = 8'h3F; en = 1; ewin = 1'b0; ewe = 1'b0;
            end
            wait_tx(en, 1'b1, got);
            cycles(2);
            checks++; if (tx_q.size() !== en || tx_at(0) !== e0 || (en == 2 && tx_at(1) !== e1)) begin failures++;
                $display("FAIL rand_reply[%0d]: n=%0d %h %h want %0d %h %h", it, tx_q.size(), tx_at(0), tx_at(1), en, e0, e1); end
            get_win(0, a, d, we, len, ok, txv);
            checks++; if (q_len.size() !== (ewin ? 1 : 0) ||
                          (ewin && (a !== ra || we !== ewe || (ewe && d !== rd) || len !== WAITC || ok !== 1'b1))) begin failures++;
                $display("FAIL rand_window[%0d]: n=%0d addr=%h dat=%h we=%b len=%0d ok=%b want %0d %h %h %b %0d 1",
                         it, q_len.size(), a, d, we, len, ok, ewin ? 1 : 0, ra, rd, ewe, WAITC); end
        end
    endtask

    task automatic test_reset_mid_bus();
        int got; logic [15:0] a, d; logic we, ok, txv; int len;
        clear_mon();
        send_write(16'h00F0, 16'h1111, 0);
        checks++; if (o_wb_cyc !== 1'b1) begin failures++;
            $display("FAIL midbus_setup: cyc=%b want 1", o_wb_cyc); end
        #1 i_reset = 1'b0;
        #1;
        checks++; if (o_wb_cyc !== 1'b0 || o_busreq !== 1'b0 || o_tx_valid !== 1'b0 || o_wb_we !== 1'b0) begin failures++;
            $display("FAIL midbus_async_reset: cyc=%b busreq=%b tx_valid=%b we=%b want 0000", o_wb_cyc, o_busreq, o_tx_valid, o_wb_we); end
        @(posedge i_clk); @(posedge i_clk); #3 i_reset = 1'b1;
        cycles(2);
        clear_mon();
        send_write(16'h0200, 16'hBEEF, 2);
        ref_mem[16'h0200] = 16'hBEEF;
        wait_tx(1, 1'b0, got);
        cycles(2);
        get_win(0, a, d, we, len, ok, txv);
        checks++; if (tx_at(0) !== 8'h4B || q_len.size() !== 1 || a !== 16'h0200 || d !== 16'hBEEF || len !== WAITC) begin failures++;
            $display("FAIL after_reset_write: reply=%h n=%0d addr=%h dat=%h len=%0d want 4b 1 0200 beef %0d", tx_at(0), q_len.size(), a, d, len, WAITC); end
        checks++; if (busreq_bad !== 0) begin failures++;
            $display("FAIL busreq_tracks_cyc: %0d cycles differ want 0", busreq_bad); end
    endtask

    initial begin
        for (int k = 0; k < 65536; k++) slave_mem[k] = 16'(k) ^ 16'h5A5A;
        test_reset();
        test_write();
        test_read_stall();
        test_unknown();
        test_timeout();
        test_wait_cycles();
        test_random();
        test_reset_mid_bus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
